// File: rtl/reset_sequencer.sv
// Board-level reset generator: synchronises and debounces the active-low button,
// holds all channels in reset for HOLD cycles, then releases them one by one.
module reset_sequencer #(
  parameter int CHANNELS = 3,
  parameter int DEBOUNCE = 16,
  parameter int HOLD     = 4095,
  parameter int STAGGER  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                n_button,
  output logic [CHANNELS-1:0] rst_out,
  output logic                all_released,
  output logic [1:0]          phase,
  output logic [7:0]          press_count
);

  typedef enum logic [1:0] {
    S_PRESS   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]    STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [3:0]          LAST_CH   = 4'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ALL_ONES  = {CHANNELS{1'b1}};
  localparam logic [CHANNELS-1:0] ONE_HOT0  = CHANNELS'(1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_pressed_db;
  logic [CNT_W-1:0]    r_db_cnt;
  logic [7:0]          r_press_count;
  state_t              r_state;
  logic [CNT_W-1:0]    r_hold_cnt;
  logic [CNT_W-1:0]    r_stag_cnt;
  logic [3:0]          r_ch;
  logic [CHANNELS-1:0] r_rst_out;
  logic                r_all_released;

  // The synchronised level is low while pressed, so it "differs" when it equals pressed_db.
  logic w_differ;
  assign w_differ = (r_sync2 == r_pressed_db);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_pressed_db  <= 1'b0;
      r_db_cnt      <= '0;
      r_press_count <= '0;
    end else begin
      r_sync1 <= n_button;
      r_sync2 <= r_sync1;
      if (w_differ) begin
        if (r_db_cnt == DB_LAST) begin
          r_pressed_db <= ~r_pressed_db;
          r_db_cnt     <= '0;
          if (!r_pressed_db) r_press_count <= r_press_count + 8'd1;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_HOLD;
      r_hold_cnt     <= '0;
      r_stag_cnt     <= '0;
      r_ch           <= '0;
      r_rst_out      <= ALL_ONES;
      r_all_released <= 1'b0;
    end else if (r_state != S_PRESS && r_pressed_db) begin
      // A debounced press wins over any release scheduled on this edge.
      r_state        <= S_PRESS;
      r_hold_cnt     <= '0;
      r_stag_cnt     <= '0;
      r_ch           <= '0;
      r_rst_out      <= ALL_ONES;
      r_all_released <= 1'b0;
    end else begin
      case (r_state)
        S_PRESS: begin
          r_rst_out      <= ALL_ONES;
          r_all_released <= 1'b0;
          if (!r_pressed_db) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            if (CHANNELS == 1) begin
              r_state        <= S_RUN;
              r_rst_out      <= '0;
              r_all_released <= 1'b1;
            end else begin
              r_state    <= S_RELEASE;
              r_rst_out  <= ALL_ONES & ~ONE_HOT0;
              r_ch       <= 4'd1;
              r_stag_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_stag_cnt == STAG_LAST) begin
            r_rst_out  <= r_rst_out & ~(ONE_HOT0 << r_ch);
            r_stag_cnt <= '0;
            r_ch       <= r_ch + 4'd1;
            if (r_ch == LAST_CH) begin
              r_state        <= S_RUN;
              r_all_released <= 1'b1;
            end
          end else begin
            r_stag_cnt <= r_stag_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_rst_out      <= '0;
          r_all_released <= 1'b1;
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  assign rst_out      = r_rst_out;
  assign all_released = r_all_released;
  assign phase        = r_state;
  assign press_count  = r_press_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: constant vector table, hand-written corner sequences,
// and random button/reset traffic against a timeline-based reference model.
module tb_reset_sequencer;

  localparam int CHANNELS = 3;
  localparam int DEBOUNCE = 4;
  localparam int HOLD     = 20;
  localparam int STAGGER  = 5;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                n_button = 1'b1;
  logic [CHANNELS-1:0] rst_out;
  logic                all_released;
  logic [1:0]          phase;
  logic [7:0]          press_count;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .CHANNELS(CHANNELS), .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .STAGGER(STAGGER), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .n_button(n_button),
    .rst_out(rst_out), .all_released(all_released), .phase(phase), .press_count(press_count)
  );

  always #5 clock = ~clock;

  // Reference model: button debounced as a run-length of disagreeing samples;
  // the sequencer is a single "cycles since hold started" timeline.
  bit m_sync1, m_sync2, m_pressed, m_pressing;
  int m_run, m_presses, m_elapsed;

  task automatic model_update(input bit rst, input bit btn);
    bit old_pressed;
    if (rst) begin
      m_sync1 = 1; m_sync2 = 1; m_pressed = 0; m_run = 0;
      m_presses = 0; m_pressing = 0; m_elapsed = 0;
      return;
    end
    old_pressed = m_pressed;
    if ((m_sync2 == 1'b0) != m_pressed) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_pressed = !m_pressed;
        m_run = 0;
        if (m_pressed) m_presses = (m_presses + 1) % 256;
      end
    end else begin
      m_run = 0;
    end
    m_sync2 = m_sync1;
    m_sync1 = btn;
    if (m_pressing) begin
      if (!old_pressed) begin m_pressing = 0; m_elapsed = 0; end
    end else if (old_pressed) begin
      m_pressing = 1;
    end else if (m_elapsed < 1000) begin
      m_elapsed++;
    end
  endtask

  function automatic logic [13:0] model_vec();
    int n;
    logic [2:0] ro;
    logic [1:0] ph;
    n = (m_elapsed < HOLD) ? 0 : (m_elapsed - HOLD) / STAGGER + 1;
    if (n > CHANNELS) n = CHANNELS;
    ro = 3'(3'b111 << n);
    ph = (n == 0) ? 2'd1 : (n < CHANNELS) ? 2'd2 : 2'd3;
    if (m_pressing) return {3'b111, 1'b0, 2'd0, 8'(m_presses)};
    return {ro, (n == CHANNELS), ph, 8'(m_presses)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {rst_out, all_released, phase, press_count};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got rst=%b rel=%b ph=%0d cnt=%0d expected rst=%b rel=%b ph=%0d cnt=%0d",
               name, act[13:11], act[10], act[9:8], act[7:0], exp[13:11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  // Inputs change at negedge; outputs are compared at the following negedge.
  task automatic step(input bit rst, input bit btn);
    reset = rst;
    n_button = btn;
    @(posedge clock);
    model_update(rst, btn);
    @(negedge clock);
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    bit         rst;
    bit         btn;
    int         n;
    logic [2:0] ro;
    bit         rel;
    logic [1:0] ph;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1, 1, 3,  3'b111, 0, 2'd1, 8'd0};
    tbl[1]  = '{0, 1, 19, 3'b111, 0, 2'd1, 8'd0};
    tbl[2]  = '{0, 1, 1,  3'b110, 0, 2'd2, 8'd0};
    tbl[3]  = '{0, 1, 4,  3'b110, 0, 2'd2, 8'd0};
    tbl[4]  = '{0, 1, 1,  3'b100, 0, 2'd2, 8'd0};
    tbl[5]  = '{0, 1, 4,  3'b100, 0, 2'd2, 8'd0};
    tbl[6]  = '{0, 1, 1,  3'b000, 1, 2'd3, 8'd0};
    tbl[7]  = '{0, 0, 3,  3'b000, 1, 2'd3, 8'd0};
    tbl[8]  = '{0, 1, 10, 3'b000, 1, 2'd3, 8'd0};
    tbl[9]  = '{0, 0, 5,  3'b000, 1, 2'd3, 8'd0};
    tbl[10] = '{0, 0, 1,  3'b000, 1, 2'd3, 8'd1};
    tbl[11] = '{0, 0, 1,  3'b111, 0, 2'd0, 8'd1};
    tbl[12] = '{0, 0, 5,  3'b111, 0, 2'd0, 8'd1};
    tbl[13] = '{0, 1, 5,  3'b111, 0, 2'd0, 8'd1};
    tbl[14] = '{0, 1, 1,  3'b111, 0, 2'd0, 8'd1};
    tbl[15] = '{0, 1, 1,  3'b111, 0, 2'd1, 8'd1};
    tbl[16] = '{0, 1, 19, 3'b111, 0, 2'd1, 8'd1};
    tbl[17] = '{0, 1, 1,  3'b110, 0, 2'd2, 8'd1};
    tbl[18] = '{0, 1, 5,  3'b100, 0, 2'd2, 8'd1};
    tbl[19] = '{0, 1, 5,  3'b000, 1, 2'd3, 8'd1};

    @(negedge clock);

    // Power-up, glitch in RUN, press in RUN and its release.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].btn);
      check($sformatf("table%0d", i), dut_vec(),
            {tbl[i].ro, tbl[i].rel, tbl[i].ph, tbl[i].cnt});
    end

    // Reset one cycle at hold_cnt=12; channel 0 must release 20 edges later.
    step(1, 1);
    repeat (12) step(0, 1);
    step(1, 1);
    repeat (19) step(0, 1);
    check("rst_mid_hold_19", dut_vec(), {3'b111, 1'b0, 2'd1, 8'd0});
    step(0, 1);
    check("rst_mid_hold_20", dut_vec(), {3'b110, 1'b0, 2'd2, 8'd0});

    // Press accepted during RELEASE on the edge channel 1 was due.
    step(1, 1);
    repeat (18) step(0, 1);
    repeat (6) step(0, 0);
    check("rel_press_before", dut_vec(), {3'b110, 1'b0, 2'd2, 8'd1});
    step(0, 0);
    check("rel_press_collide", dut_vec(), {3'b111, 1'b0, 2'd0, 8'd1});
    repeat (4) step(0, 0);
    repeat (40) step(0, 1);
    check("rel_press_rerun", dut_vec(), {3'b000, 1'b1, 2'd3, 8'd1});

    // 256 clean presses wrap the counter; sequencing still completes.
    step(1, 1);
    repeat (256) begin
      repeat (6) step(0, 0);
      repeat (8) step(0, 1);
    end
    check("wrap_count", {6'd0, press_count}, 14'd0);
    repeat (32) step(0, 1);
    check("wrap_run", dut_vec(), {3'b000, 1'b1, 2'd3, 8'd0});

    // Random button runs with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 3000;) begin
      bit lvl;
      int len;
      lvl = ($urandom_range(0, 1) == 1);
      len = lvl ? $urandom_range(1, 60) : $urandom_range(1, 10);
      for (int j = 0; j < len; j++) step(($urandom_range(0, 499) == 0), lvl);
      i += len;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for the board top level. It synchronises and debounces the raw active-low pushbutton and holds reset for a programmable interval after the button is released. It then releases a configurable number of downstream reset channels one at a time at a fixed stagger, e.g. memories first, then processor, then display drivers. It succeeds the single-channel hold counter in the top level and adds debouncing, per-channel staggered release, status outputs and a press counter.

## Interface
Parameters:
- CHANNELS, 3: number of reset outputs; legal range 1..8.
- DEBOUNCE, 16: consecutive stable cycles required to accept a button change; must be ≥1.
- HOLD, 4095: cycles all channels stay asserted after the button is released or after `reset` deasserts; must be ≥1.
- STAGGER, 16: cycles between successive channel releases; must be ≥1; unused when CHANNELS=1.
- CNT_W, 16: width of the debounce, hold and stagger counters; every count parameter must be < 2^CNT_W.

Ports:
- clock  in  1  single system clock (PLL output); all state changes on its rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs on the same edge.
- n_button  in  1  raw pushbutton, active-low, asynchronous to `clock`.
- rst_out  out  CHANNELS  active-high resets to downstream blocks; bit k is released k-th.
- all_released  out  1  high only in RUN.
- phase  out  2  current FSM state: 0=PRESS, 1=HOLD, 2=RELEASE, 3=RUN.
- press_count  out  8  count of accepted presses; wraps from 255 to 0.

## Operation
- Synchroniser: two flops on `n_button`, both reset to 1 (not pressed). The second flop's output is the synchronised button value.
- Debounce state: `pressed_db` register, reset value 0.
- Debounce counter `db_cnt`: `differ` is true when the synchronised value disagrees with `~pressed_db`.
  - If `differ` and `db_cnt==DEBOUNCE-1`: toggle `pressed_db` and clear `db_cnt`.
  - Else if `differ`: increment `db_cnt`.
  - Else: clear `db_cnt`.
- press_count increments on the same edge that `pressed_db` goes 0→1.
- FSM, all outputs registered:
  - PRESS: rst_out all 1. When `pressed_db`=0, go to HOLD and clear hold_cnt.
  - HOLD: rst_out all 1; hold_cnt increments each cycle. When `hold_cnt==HOLD-1`, go to RELEASE on that edge, clear rst_out[0], set ch=1 and clear stag_cnt.
  - RELEASE: stag_cnt increments each cycle. When `stag_cnt==STAGGER-1`, clear rst_out[ch], increment ch and clear stag_cnt. The edge that clears rst_out[CHANNELS-1] also moves the FSM to RUN and sets all_released.
  - HOLD→RUN special case: when CHANNELS=1, the HOLD exit edge goes directly to RUN.
  - RUN: rst_out all 0, all_released=1.
  - Press override: in HOLD, RELEASE or RUN, `pressed_db`=1 moves the FSM to PRESS. On that edge rst_out goes all 1, all_released goes 0, and hold_cnt, stag_cnt and ch are cleared.
- Reset values: FSM state HOLD; all counters 0; rst_out all 1; all_released 0; phase 1; press_count 0; pressed_db 0. A power-up or PLL-lock reset therefore runs the full hold/stagger sequence.
- Reset mid-operation: any state returns to these values on the edge where `reset`=1. The hold count restarts from 0 after `reset` deasserts.
- No output ever goes X after reset. rst_out channels never re-assert individually; re-assertion is always all channels together.

## Timing
- Power-up sequence: let edge 1 be the first edge with `reset`=0.
  - rst_out[0] falls after edge HOLD.
  - rst_out[k] falls after edge HOLD + k·STAGGER.
  - all_released rises on the same edge as the last channel release.
- Press latency: if `n_button` is first sampled low at edge e and stays low:
  - `pressed_db` and press_count update at edge e+DEBOUNCE+1.
  - rst_out goes all 1 and phase becomes 0 at edge e+DEBOUNCE+2.
- Glitch rejection: a low pulse shorter than DEBOUNCE synchronised cycles causes no state change.
- Release latency: the button-release edge follows the same debounce timing. Then HOLD cycles elapse, then the stagger sequence runs.
- Simultaneous events: `reset` beats everything. A debounced press beats a channel release scheduled on the same edge, so rst_out goes all 1.

## Test plan
Parameters for all scenarios: CHANNELS=3, DEBOUNCE=4, HOLD=20, STAGGER=5.
- Power-up: `reset` high for 3 cycles, then low, with the button idle. Required response:
  - rst_out=111 through edge 19, 110 after edge 20, 100 after edge 25.
  - 000 with all_released=1 and phase=3 after edge 30.
- Glitch in RUN: `n_button` low for 3 cycles. Required response: no change; phase=3 and press_count=0.
- Press in RUN: `n_button` low from sampled edge e for 12 cycles, then high. Required response:
  - press_count=1 at e+5; rst_out=111 and phase=0 at e+6.
  - After the button is released and debounced, phase=1, then HOLD+stagger as in power-up.
- Press during RELEASE: press accepted after rst_out=110. Required response: rst_out returns to 111 and all_released stays 0.
- Reset mid-HOLD: `reset` asserted for 1 cycle at hold_cnt=12. Required response: rst_out=111 and hold restarts, so channel 0 releases exactly 20 edges after `reset` deasserts.
- press_count wrap: 256 clean presses. Required response: press_count reads 0 and rst_out sequencing is unaffected.
